// File: rtl/rgb_led_pwm_driver_if.sv
// Pin bundle between the SoC LED register / switches and the RGB LED PWM driver.
// The master side supplies the pattern and settings; the slave side (driver) returns the LED pins.
interface rgb_led_pwm_driver_if #(
   parameter int NUM_LEDS = 4
);
   logic [2*NUM_LEDS-1:0] soc_led;
   logic [1:0]            bright;
   logic                  enable;
   logic [3*NUM_LEDS-1:0] led;
   logic                  frame_start;

   modport master (
      output soc_led, bright, enable,
      input  led, frame_start
   );

   modport slave (
      input  soc_led, bright, enable,
      output led, frame_start
   );
endinterface

// File: rtl/rgb_led_pwm_driver.sv
// PWM-dimmed RGB LED driver: SoC LED bit pairs map to R/G/B per LED.
// Pattern and brightness are latched only at frame boundaries so a frame is never cut short.
module rgb_led_pwm_driver #(
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 16,
   parameter int NUM_LEDS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   rgb_led_pwm_driver_if.slave   bus
);

   localparam int                PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

   // Duty is one bit wider than the counter so the top setting can exceed every count (always on).
   function automatic logic [PWM_BITS:0] duty_lut(input logic [1:0] sel);
      logic [PWM_BITS:0] one;
      one = (PWM_BITS+1)'(1);
      case (sel)
         2'd0:    return one << (PWM_BITS - 3);
         2'd1:    return one << (PWM_BITS - 2);
         2'd2:    return one << (PWM_BITS - 1);
         default: return one << PWM_BITS;
      endcase
   endfunction

   logic [PW-1:0]         presc_q,   presc_d;
   logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [2*NUM_LEDS-1:0] shadow_q,  shadow_d;
   logic [PWM_BITS:0]     duty_q,    duty_d;
   logic [3*NUM_LEDS-1:0] led_q,     led_d;
   logic                  fs_q,      fs_d;
   logic                  tick;
   logic                  frame_evt;
   logic                  lit;

   always_comb begin
      tick      = (presc_q == PRESC_LAST);
      frame_evt = tick && (pwm_cnt_q == CNT_LAST);

      presc_d   = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;

      shadow_d  = frame_evt ? bus.soc_led      : shadow_q;
      duty_d    = frame_evt ? duty_lut(bus.bright) : duty_q;
      fs_d      = frame_evt;

      // enable bypasses the shadow so it takes effect on the very next edge.
      lit   = bus.enable && ({1'b0, pwm_cnt_q} < duty_q);
      led_d = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         led_d[i]              = lit & shadow_q[2*i];
         led_d[NUM_LEDS+i]     = lit & shadow_q[2*i+1];
         led_d[2*NUM_LEDS+i]   = lit & shadow_q[2*i] & shadow_q[2*i+1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
         shadow_q  <= '0;
         duty_q    <= '0;
         led_q     <= '0;
         fs_q      <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
         shadow_q  <= shadow_d;
         duty_q    <= duty_d;
         led_q     <= led_d;
         fs_q      <= fs_d;
      end
   end

   assign bus.led         = led_q;
   assign bus.frame_start = fs_q;

endmodule
